// File: rtl/csr_access_unit_pkg.sv
// Shared types for the CSR access unit: instruction ops, FSM states and CSR file commands.
package csr_access_unit_pkg;

    typedef enum logic [2:0] {
        CSR_OP_RW  = 3'd0,
        CSR_OP_RS  = 3'd1,
        CSR_OP_RC  = 3'd2,
        CSR_OP_RWI = 3'd4,
        CSR_OP_RSI = 3'd5,
        CSR_OP_RCI = 3'd6
    } csr_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } csr_acc_state_e;

    typedef enum logic [2:0] {
        CSR_N = 3'd0,
        CSR_R = 3'd2,
        CSR_I = 3'd4,
        CSR_W = 3'd5,
        CSR_S = 3'd6,
        CSR_C = 3'd7
    } ctrl_reg_cmd_e;

    // Encodings 3 and 7 have both low bits set; bit 2 selects the immediate form.
    function automatic logic op_is_valid(input logic [2:0] op);
        return op[1:0] != 2'b11;
    endfunction

    function automatic logic op_is_imm(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Request/response handshakes plus the CSR file command bus; master = access unit side.
interface csr_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    import csr_access_unit_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_src;
    logic [4:0]        req_uimm;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_illegal;

    ctrl_reg_cmd_e     csr_cmd;
    logic [ADDR_W-1:0] csr;
    logic [DATA_W-1:0] csr_wdata;
    logic [DATA_W-1:0] csr_rdata;
    logic              csr_stall;
    logic              csr_read_illegal;
    logic              csr_write_illegal;

    modport master (
        input  req_valid, req_op, req_addr, req_src, req_uimm, resp_ready,
               csr_rdata, csr_stall, csr_read_illegal, csr_write_illegal,
        output req_ready, resp_valid, resp_rdata, resp_illegal,
               csr_cmd, csr, csr_wdata
    );

    modport slave (
        output req_valid, req_op, req_addr, req_src, req_uimm, resp_ready,
               csr_rdata, csr_stall, csr_read_illegal, csr_write_illegal,
        input  req_ready, resp_valid, resp_rdata, resp_illegal,
               csr_cmd, csr, csr_wdata
    );

endinterface

// File: rtl/csr_access_unit_modify.sv
// Read-modify-write datapath: new CSR value and whether a write is needed at all.
module csr_modify
    import csr_access_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] opnd_i,
    output logic [DATA_W-1:0] new_o,
    output logic              wneed_o
);

    // Register and immediate forms share the low two bits, so decode on those only.
    always_comb begin
        new_o   = old_i;
        wneed_o = 1'b0;
        unique case (op_i[1:0])
            2'b00: begin
                new_o   = opnd_i;
                wneed_o = 1'b1;
            end
            2'b01: begin
                new_o   = old_i | opnd_i;
                wneed_o = |opnd_i;
            end
            2'b10: begin
                new_o   = old_i & ~opnd_i;
                wneed_o = |opnd_i;
            end
            default: begin
                new_o   = old_i;
                wneed_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// CSR instruction initiator: read, modify, write, respond; one instruction in flight.
// Optional write counter enabled by defining CSR_ACCESS_PERF_EN.
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    csr_access_unit_if.master    bus,
    output logic [31:0]          perf_writes
);

    csr_acc_state_e    state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic [DATA_W-1:0] old_q, old_d;
    logic [DATA_W-1:0] new_q, new_d;
    logic              illegal_q, illegal_d;

    logic [DATA_W-1:0] modify_new;
    logic              modify_wneed;

    csr_modify #(.DATA_W(DATA_W)) u_modify (
        .op_i    (op_q),
        .old_i   (bus.csr_rdata),
        .opnd_i  (opnd_q),
        .new_o   (modify_new),
        .wneed_o (modify_wneed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            opnd_q    <= '0;
            old_q     <= '0;
            new_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            opnd_q    <= opnd_d;
            old_q     <= old_d;
            new_q     <= new_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        addr_d           = addr_q;
        opnd_d           = opnd_q;
        old_d            = old_q;
        new_d            = new_q;
        illegal_d        = illegal_q;
        bus.req_ready    = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.resp_rdata   = '0;
        bus.resp_illegal = 1'b0;
        bus.csr_cmd      = CSR_N;
        bus.csr          = '0;
        bus.csr_wdata    = '0;

        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    op_d      = bus.req_op;
                    addr_d    = bus.req_addr;
                    opnd_d    = op_is_imm(bus.req_op) ? {{(DATA_W-5){1'b0}}, bus.req_uimm}
                                                      : bus.req_src;
                    illegal_d = 1'b0;
                    state_d   = READ;
                end
            end
            READ: begin
                bus.csr = addr_q;
                if (!bus.csr_stall) begin
                    old_d = bus.csr_rdata;
                    new_d = modify_new;
                    if (!op_is_valid(op_q) || bus.csr_read_illegal) begin
                        illegal_d = 1'b1;
                        state_d   = RESP;
                    end else if (modify_wneed && bus.csr_write_illegal) begin
                        illegal_d = 1'b1;
                        state_d   = RESP;
                    end else if (modify_wneed) begin
                        illegal_d = 1'b0;
                        state_d   = WRITE;
                    end else begin
                        illegal_d = 1'b0;
                        state_d   = RESP;
                    end
                end
            end
            WRITE: begin
                bus.csr       = addr_q;
                bus.csr_cmd   = CSR_W;
                bus.csr_wdata = new_q;
                if (!bus.csr_stall) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.resp_valid   = 1'b1;
                bus.resp_illegal = illegal_q;
                bus.resp_rdata   = illegal_q ? '0 : old_q;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CSR_ACCESS_PERF_EN
    logic [31:0] perf_q;
    logic        write_commit;

    assign write_commit = (state_q == WRITE) && !bus.csr_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (write_commit) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_writes = perf_q;
`else
    assign perf_writes = '0;
`endif

endmodule

// File: tb/tb_csr_access_unit.sv
// Table-driven bench for csr_access_unit with a response scoreboard and a mid-write reset sequence.
module tb_csr_access_unit;
    import csr_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] perf_writes;

    always #5 clk = ~clk;

    csr_access_unit_if bus ();

    csr_access_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .perf_writes (perf_writes)
    );

    typedef struct {
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] src;
        logic [4:0]  uimm;
        logic [31:0] csr_val;
        bit          rd_ill;
        bit          wr_ill;
        int          rd_stall;
        int          wr_stall;
        int          hold;
        bit          poke;
        bit          exp_write;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        bit          exp_ill;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          ill;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_perf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit          wrote;
        bit          done;
        bit          was_wstall;
        logic [31:0] wdata;
        int          rdl;
        int          wrl;
        exp_t        e;
        wrote = 0; done = 0; was_wstall = 0; wdata = '0;
        rdl = v.rd_stall; wrl = v.wr_stall;

        bus.csr_rdata         = v.csr_val;
        bus.csr_read_illegal  = v.rd_ill;
        bus.csr_write_illegal = v.wr_ill;
        bus.csr_stall         = 1'b0;
        bus.req_valid         = 1'b1;
        bus.req_op            = v.op;
        bus.req_addr          = v.addr;
        bus.req_src           = v.src;
        bus.req_uimm          = v.uimm;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        e.rdata = v.exp_rdata;
        e.ill   = v.exp_ill;
        e.lat   = v.exp_lat + v.rd_stall + (v.exp_write ? v.wr_stall : 0);
        sb.push_back(e);

        for (int c = 1; c <= 60 && !done; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.req_valid = v.poke;
            bus.req_op    = 3'd0;
            bus.req_addr  = 12'hBAD;
            bus.req_src   = 32'h0BAD0BAD;
            bus.csr_stall = 1'b0;
            bus.csr_rdata = v.csr_val;
            if (was_wstall) begin
                chk("wstall_cmd", 32'(bus.csr_cmd), 32'(CSR_W));
                chk("wstall_addr", 32'(bus.csr), 32'(v.addr));
                chk("wstall_wdata", bus.csr_wdata, v.exp_wdata);
                was_wstall = 0;
            end
            if (bus.resp_valid) begin
                e = sb.pop_front();
                chk("resp_latency", 32'(c), 32'(e.lat));
                chk("resp_rdata", bus.resp_rdata, e.rdata);
                chk("resp_illegal", 32'(bus.resp_illegal), 32'(e.ill));
                chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
                chk("write_seen", 32'(wrote), 32'(v.exp_write));
                if (v.exp_write) chk("write_data", wdata, v.exp_wdata);
                for (int h = 0; h < v.hold; h++) begin
                    @(posedge clk);
                    @(negedge clk);
                    bus.req_valid = 1'b0;
                    chk("hold_valid", 32'(bus.resp_valid), 32'd1);
                    chk("hold_rdata", bus.resp_rdata, e.rdata);
                    chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
                end
                bus.req_valid  = 1'b0;
                bus.resp_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                bus.resp_ready = 1'b0;
                chk("back_to_idle", 32'(bus.req_ready), 32'd1);
                chk("resp_dropped", 32'(bus.resp_valid), 32'd0);
                $display("vec %0d op=%0d addr=%03h rdata=%08h ill=%0d lat=%0d write=%0d wdata=%08h",
                         idx, v.op, v.addr, e.rdata, e.ill, c, wrote, wdata);
                done = 1;
            end else if (bus.csr_cmd == CSR_W) begin
                if (!wrote) chk("write_addr", 32'(bus.csr), 32'(v.addr));
                wrote = 1;
                wdata = bus.csr_wdata;
                if (wrl > 0) begin
                    bus.csr_stall = 1'b1;
                    wrl--;
                    was_wstall = 1;
                end else begin
                    exp_perf++;
                end
            end else if (!wrote) begin
                chk("read_addr", 32'(bus.csr), 32'(v.addr));
                if (rdl > 0) begin
                    bus.csr_stall = 1'b1;
                    bus.csr_rdata = ~v.csr_val;
                    rdl--;
                end
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout vec %0d: no response within 60 cycles", idx);
            sb.delete();
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic reset_during_write();
        bus.csr_rdata         = 32'h12345678;
        bus.csr_read_illegal  = 1'b0;
        bus.csr_write_illegal = 1'b0;
        bus.csr_stall         = 1'b0;
        bus.req_valid         = 1'b1;
        bus.req_op            = 3'd0;
        bus.req_addr          = 12'h0AA;
        bus.req_src           = 32'h5A5A5A5A;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_pre_cmd", 32'(bus.csr_cmd), 32'(CSR_W));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_cmd", 32'(bus.csr_cmd), 32'(CSR_N));
        chk("rst_async_csr", 32'(bus.csr), 32'd0);
        chk("rst_async_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_async_ready", 32'(bus.req_ready), 32'd1);
        exp_perf = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        $display("reset during WRITE: abandoned, no response");
    endtask

    initial begin
        //          op    addr    src           uimm   csr_val       ri wi rs ws hd pk w  wdata         rdata         il lat
        vecs[0]  = '{3'd0, 12'h00F, 32'hDEADBEEF, 5'h00, 32'h12345678, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 32'h12345678, 0, 3};
        vecs[1]  = '{3'd1, 12'h300, 32'h00000000, 5'h1F, 32'hAAAA5555, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'hAAAA5555, 0, 2};
        vecs[2]  = '{3'd5, 12'h301, 32'hFFFFFFFF, 5'h05, 32'h000000F0, 0, 0, 0, 0, 0, 0, 1, 32'h000000F5, 32'h000000F0, 0, 3};
        vecs[3]  = '{3'd2, 12'h302, 32'h0000FFFF, 5'h00, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD0000, 32'hDEADBEEF, 0, 3};
        vecs[4]  = '{3'd0, 12'h303, 32'h00000001, 5'h00, 32'h00000055, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 2};
        vecs[5]  = '{3'd3, 12'h304, 32'h00000001, 5'h00, 32'h00000055, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 2};
        vecs[6]  = '{3'd6, 12'h305, 32'h00000000, 5'h1F, 32'h000000FF, 0, 0, 0, 0, 0, 0, 1, 32'h000000E0, 32'h000000FF, 0, 3};
        vecs[7]  = '{3'd4, 12'h306, 32'hFFFFFFFF, 5'h00, 32'h00000077, 0, 0, 0, 0, 0, 0, 1, 32'h00000000, 32'h00000077, 0, 3};
        vecs[8]  = '{3'd1, 12'h307, 32'h00000001, 5'h00, 32'h00000099, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 2};
        vecs[9]  = '{3'd1, 12'h308, 32'h00000000, 5'h00, 32'h00000042, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h00000042, 0, 2};
        vecs[10] = '{3'd7, 12'h309, 32'h00000003, 5'h03, 32'h00000011, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 2};
        vecs[11] = '{3'd5, 12'h30A, 32'hFFFFFFFF, 5'h00, 32'h00000010, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h00000010, 0, 2};
        vecs[12] = '{3'd0, 12'h7C0, 32'hCAFEF00D, 5'h00, 32'h0BADC0DE, 0, 0, 2, 1, 0, 0, 1, 32'hCAFEF00D, 32'h0BADC0DE, 0, 3};
        vecs[13] = '{3'd2, 12'h7C1, 32'h0000000F, 5'h00, 32'h000000FF, 0, 0, 0, 0, 3, 1, 1, 32'h000000F0, 32'h000000FF, 0, 3};
        vecs[14] = '{3'd1, 12'h7C2, 32'h00000100, 5'h00, 32'h0000000F, 0, 0, 1, 0, 0, 0, 1, 32'h0000010F, 32'h0000000F, 0, 3};
        vecs[15] = '{3'd0, 12'h7C3, 32'h00000001, 5'h00, 32'h00000033, 1, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        1, 2};

        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_src = '0; bus.req_uimm = '0;
        bus.resp_ready = 1'b0; bus.csr_rdata = '0; bus.csr_stall = 1'b0;
        bus.csr_read_illegal = 1'b0; bus.csr_write_illegal = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset_resp_illegal", 32'(bus.resp_illegal), 32'd0);
        chk("reset_resp_rdata", bus.resp_rdata, 32'd0);
        chk("reset_csr_cmd", 32'(bus.csr_cmd), 32'(CSR_N));
        chk("reset_csr", 32'(bus.csr), 32'd0);
        chk("reset_csr_wdata", bus.csr_wdata, 32'd0);
        chk("reset_perf", perf_writes, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        reset_during_write();
        run_vec(vecs[0], 16);
        run_vec(vecs[3], 17);

`ifdef CSR_ACCESS_PERF_EN
        chk("perf_writes", perf_writes, 32'(exp_perf));
`else
        chk("perf_writes_tied", perf_writes, 32'd0);
`endif
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
Initiator side of the CSR command interface. It sits in the execute stage and accepts one CSR instruction at a time from the pipeline over a valid/ready handshake. For each instruction it reads the target CSR, computes the modified value, and issues the write to the CSR file. It returns the old CSR value and an illegal flag to writeback over a second valid/ready handshake.

Parameters:
DATA_W, 32, CSR data width; must match the CSR file.
ADDR_W, 12, CSR address width.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
req_valid  in  1  CSR instruction request valid
req_ready  out  1  unit can accept a request
req_op  in  3  Bundle::CsrOp: RW=0, RS=1, RC=2, RWI=4, RSI=5, RCI=6; 3 and 7 are invalid
req_addr  in  ADDR_W  CSR address
req_src  in  DATA_W  rs1 value, used by RW/RS/RC
req_uimm  in  5  immediate, used by RWI/RSI/RCI; zero-extended
resp_valid  out  1  result valid
resp_ready  in  1  writeback accepts result
resp_rdata  out  DATA_W  old CSR value; 0 when illegal
resp_illegal  out  1  access was illegal
csr_cmd  out  Bundle::ControlRegisterCommand  command to the CSR file
csr  out  ADDR_W  CSR address to the CSR file
csr_wdata  out  DATA_W  write data to the CSR file
csr_rdata  in  DATA_W  read data from the CSR file
csr_stall  in  1  CSR file not ready; hold the current phase
csr_read_illegal  in  1  decoded read is illegal
csr_write_illegal  in  1  decoded write is illegal

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; resp_valid=0, resp_illegal=0, resp_rdata=0.
  - csr_cmd=CSR_N, csr=0, csr_wdata=0.
  - all internal registers 0.
- Register names: opnd = operand, old = value read from the CSR, new = value to write.
- IDLE:
  - req_ready=1; CSR outputs idle (CSR_N, 0, 0).
  - On req_valid: latch op and addr.
  - opnd = req_uimm zero-extended for the I-variants, else req_src.
  - Go to READ.
- READ:
  - Drive csr=addr, csr_cmd=CSR_N.
  - If csr_stall=1: stay in READ.
  - Otherwise capture old=csr_rdata.
  - Compute new: RW/RWI → opnd; RS/RSI → old|opnd; RC/RCI → old&~opnd.
  - wneed = 1 for RW/RWI; for RS/RC/RSI/RCI, wneed = (opnd != 0).
  - Transition priority:
    - invalid op or csr_read_illegal → RESP, illegal=1;
    - else wneed and csr_write_illegal → RESP, illegal=1, no write;
    - else wneed → WRITE;
    - else → RESP, illegal=0.
- WRITE:
  - Drive csr=addr, csr_cmd=CSR_W, csr_wdata=new.
  - The write commits on the first WRITE cycle with csr_stall=0; then go to RESP.
  - While csr_stall=1, hold all outputs stable.
- RESP:
  - resp_valid=1; resp_rdata = old (0 if illegal); resp_illegal as captured.
  - Outputs hold stable until resp_ready=1; then go to IDLE.
  - req_ready=0 in every state except IDLE: one instruction outstanding at most.
- Latency without stalls:
  - request accepted in cycle 0; READ in cycle 1; WRITE in cycle 2; resp_valid in cycle 3.
  - with no write: resp_valid in cycle 2.
  - Each stall cycle adds 1.
- Reset asserted mid-operation: the instruction is abandoned and no response is produced. If asserted during WRITE, csr_cmd returns to CSR_N asynchronously.
- req_valid while not in IDLE: ignored, not latched.

Optional Feature:
- Macro: CSR_ACCESS_PERF_EN.
- Defined:
  - adds output perf_writes [31:0], a count of committed CSR_W writes;
  - increments in the WRITE cycle where csr_stall=0; wraps modulo 2^32; reset to 0.
- Undefined: the perf_writes port exists and is tied to 0; no counter logic is built.

Decomposition:
- Bundle package:
  - CsrOp enum;
  - CsrAccState enum (IDLE, READ, WRITE, RESP);
  - existing ControlRegisterCommand (CSR_N/CSR_W used).
- Sub-module csr_modify (combinational):
  - inputs op, old, opnd;
  - outputs new and wneed.
- The FSM and registers stay in csr_access_unit.

Test Plan:
- RW, addr 0x00F, src 0xDEADBEEF, CSR holds 0x12345678 → CSR_W with wdata 0xDEADBEEF in cycle 2; resp_valid in cycle 3 with resp_rdata=0x12345678, resp_illegal=0.
- RS, src 0 → no CSR_W ever driven; resp in cycle 2 with the old value. RSI, uimm 0x05, old 0xF0 → wdata 0xF5.
- RC, src 0x0000FFFF, old 0xDEADBEEF → wdata 0xDEAD0000; resp_rdata=0xDEADBEEF.
- csr_stall=1 for 2 cycles in READ and 1 cycle in WRITE → resp_valid in cycle 6; CSR outputs stable throughout.
- RW with csr_write_illegal=1 → no CSR_W; resp_illegal=1, resp_rdata=0. Op 3 → illegal with no write.
- resp_ready low for 3 cycles → response held and req_ready=0. Reset pulse during WRITE → immediate CSR_N, state IDLE, resp_valid=0.
